// File: rtl/hit_window_counter.sv
// hit_window_counter: counts hit edges and cycles inside start/stop windows,
// delivering one result per closed window through a valid/ready register.
module hit_window_counter #(
  parameter int CNT_WIDTH = 24,
  parameter int WIN_WIDTH = 20
) (
  input  logic                 clk40M,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 hit_in,
  input  logic                 res_ready,
  output logic                 res_valid,
  output logic [CNT_WIDTH-1:0] res_hits,
  output logic [WIN_WIDTH-1:0] res_cycles,
  output logic                 res_ovf,
  output logic [7:0]           lost_cnt,
  output logic                 busy
);
  typedef enum logic {IDLE, COUNT} state_t;
  state_t r_state, w_state_nxt;
  logic r_hit_q, r_ovf_acc, w_ovf_nxt, w_ovf_inc;
  logic [CNT_WIDTH-1:0] r_hit_cnt, w_hit_nxt, w_hit_inc;
  logic [WIN_WIDTH-1:0] r_win_cnt, w_win_nxt, w_win_inc;
  logic r_res_valid, r_res_ovf;
  logic [CNT_WIDTH-1:0] r_res_hits;
  logic [WIN_WIDTH-1:0] r_res_cycles;
  logic [7:0] r_lost;
  logic w_edge, w_hit_max, w_win_max, w_close, w_abort, w_load, w_lost_inc;
  assign w_edge     = hit_in & ~r_hit_q;
  assign w_hit_max  = &r_hit_cnt;
  assign w_win_max  = &r_win_cnt;
  // Values this cycle would produce; a closing window reports these directly.
  assign w_hit_inc  = (w_edge && !w_hit_max) ? r_hit_cnt + CNT_WIDTH'(1) : r_hit_cnt;
  assign w_win_inc  = w_win_max ? r_win_cnt : r_win_cnt + WIN_WIDTH'(1);
  assign w_ovf_inc  = r_ovf_acc | (w_edge & w_hit_max) | w_win_max;
  assign w_close    = (r_state == COUNT) && stop;
  assign w_abort    = (r_state == COUNT) && start && !stop;
  assign w_load     = w_close && (!r_res_valid || res_ready);
  assign w_lost_inc = (w_close && !w_load) || w_abort;
  always_comb begin
    w_state_nxt = r_state;
    w_hit_nxt   = r_hit_cnt;
    w_win_nxt   = r_win_cnt;
    w_ovf_nxt   = r_ovf_acc;
    if (start) begin
      w_state_nxt = COUNT;
      w_hit_nxt   = '0;
      w_win_nxt   = '0;
      w_ovf_nxt   = 1'b0;
    end else if (r_state == COUNT) begin
      w_state_nxt = stop ? IDLE : COUNT;
      w_hit_nxt   = w_hit_inc;
      w_win_nxt   = w_win_inc;
      w_ovf_nxt   = w_ovf_inc;
    end
  end
  always_ff @(posedge clk40M or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_hit_q      <= 1'b0;
      r_hit_cnt    <= '0;
      r_win_cnt    <= '0;
      r_ovf_acc    <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_hits   <= '0;
      r_res_cycles <= '0;
      r_res_ovf    <= 1'b0;
      r_lost       <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_hit_q   <= hit_in;
      r_hit_cnt <= w_hit_nxt;
      r_win_cnt <= w_win_nxt;
      r_ovf_acc <= w_ovf_nxt;
      if (w_load) begin
        r_res_valid  <= 1'b1;
        r_res_hits   <= w_hit_inc;
        r_res_cycles <= w_win_inc;
        r_res_ovf    <= w_ovf_inc;
      end else if (res_ready) begin
        r_res_valid <= 1'b0;
      end
      if (w_lost_inc && r_lost != 8'hFF) r_lost <= r_lost + 8'd1;
    end
  end
  assign res_valid  = r_res_valid;
  assign res_hits   = r_res_hits;
  assign res_cycles = r_res_cycles;
  assign res_ovf    = r_res_ovf;
  assign lost_cnt   = r_lost;
  assign busy       = (r_state == COUNT);
endmodule

// File: tb/tb_hit_window_counter.sv
// tb_hit_window_counter: directed checks of window counting, backpressure,
// saturation (narrow second instance), reset and abort behaviour.
module tb_hit_window_counter;
  logic clk40M = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, hit_in = 1'b0, res_ready = 1'b1;
  logic res_valid, res_ovf, busy, v2, o2, b2;
  logic [23:0] res_hits;
  logic [19:0] res_cycles;
  logic [7:0] lost_cnt, l2, c2;
  logic [3:0] h2;
  int checks = 0, errors = 0, bad;
  always #12 clk40M = ~clk40M;
  hit_window_counter dut (
    .clk40M(clk40M), .rst_n(rst_n), .start(start), .stop(stop), .hit_in(hit_in),
    .res_ready(res_ready), .res_valid(res_valid), .res_hits(res_hits),
    .res_cycles(res_cycles), .res_ovf(res_ovf), .lost_cnt(lost_cnt), .busy(busy)
  );
  hit_window_counter #(.CNT_WIDTH(4), .WIN_WIDTH(8)) dut_narrow (
    .clk40M(clk40M), .rst_n(rst_n), .start(start), .stop(stop), .hit_in(hit_in),
    .res_ready(res_ready), .res_valid(v2), .res_hits(h2),
    .res_cycles(c2), .res_ovf(o2), .lost_cnt(l2), .busy(b2)
  );
  task automatic tick();
    @(posedge clk40M);
    #1;
  endtask
  task automatic drive(input logic s, input logic p, input logic h);
    start = s;
    stop = p;
    hit_in = h;
    tick();
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    chk("rst_valid", res_valid, 0);
    chk("rst_hits", res_hits, 0);
    chk("rst_cycles", res_cycles, 0);
    chk("rst_lost", lost_cnt, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    // basic window: pulses at +5, +20, +50, stop at +100
    bad = 0;
    drive(1, 0, 0);
    chk("t1_busy_rise", busy, 1);
    for (int i = 1; i <= 100; i++) begin
      drive(0, i == 100, i inside {5, 6, 20, 21, 50, 51});
      if (i < 100 && res_valid) bad++;
    end
    chk("t1_no_early_valid", bad, 0);
    chk("t1_valid", res_valid, 1);
    chk("t1_hits", res_hits, 3);
    chk("t1_cycles", res_cycles, 100);
    chk("t1_ovf", res_ovf, 0);
    chk("t1_busy_fall", busy, 0);
    drive(0, 0, 0);
    chk("t1_valid_drop", res_valid, 0);
    // edge in start cycle ignored, edge in stop cycle counted
    drive(1, 0, 1);
    for (int i = 1; i <= 10; i++) drive(0, i == 10, i == 10);
    chk("t2_hits", res_hits, 1);
    chk("t2_cycles", res_cycles, 10);
    drive(0, 0, 0);
    // backpressure: second result dropped
    res_ready = 1'b0;
    drive(1, 0, 0);
    for (int i = 1; i <= 12; i++) drive(0, i == 12, (i % 2 == 1) && i <= 9);
    chk("t3_first_hits", res_hits, 5);
    drive(1, 0, 0);
    for (int i = 1; i <= 16; i++) drive(0, i == 16, (i % 2 == 1) && i <= 13);
    chk("t3_held_valid", res_valid, 1);
    chk("t3_held_hits", res_hits, 5);
    chk("t3_held_cycles", res_cycles, 12);
    chk("t3_lost", lost_cnt, 1);
    res_ready = 1'b1;
    drive(0, 0, 0);
    chk("t3_drained", res_valid, 0);
    // chained windows
    bad = 0;
    drive(1, 0, 0);
    if (!busy) bad++;
    for (int i = 1; i <= 40; i++) begin
      drive(i == 40, i == 40, 0);
      if (!busy) bad++;
    end
    chk("t4_first_valid", res_valid, 1);
    chk("t4_first_cycles", res_cycles, 40);
    for (int i = 41; i <= 70; i++) begin
      drive(0, i == 70, 0);
      if (i == 41) chk("t4_taken", res_valid, 0);
      if (i < 70 && !busy) bad++;
    end
    chk("t4_busy_high", bad, 0);
    chk("t4_second_cycles", res_cycles, 30);
    chk("t4_busy_low", busy, 0);
    chk("t4_lost_kept", lost_cnt, 1);
    drive(0, 0, 0);
    // saturation: 20 edges in one window
    drive(1, 0, 0);
    for (int i = 1; i <= 40; i++) drive(0, i == 40, i % 2 == 1);
    chk("t5_wide_hits", res_hits, 20);
    chk("t5_wide_ovf", res_ovf, 0);
    chk("t5_nar_hits", h2, 15);
    chk("t5_nar_ovf", o2, 1);
    chk("t5_nar_cycles", c2, 40);
    drive(1, 0, 0);
    for (int i = 1; i <= 6; i++) drive(0, i == 6, i inside {1, 3});
    chk("t5_nar_hits2", h2, 2);
    chk("t5_nar_ovf2", o2, 0);
    drive(1, 0, 0);
    for (int i = 1; i <= 300; i++) drive(0, i == 300, 0);
    chk("t5_win_wide", res_cycles, 300);
    chk("t5_win_wide_ovf", res_ovf, 0);
    chk("t5_win_nar", c2, 255);
    chk("t5_win_nar_ovf", o2, 1);
    drive(0, 0, 0);
    // reset mid-window
    drive(1, 0, 0);
    for (int i = 1; i <= 10; i++) drive(0, 0, i % 3 == 0);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_valid", res_valid, 0);
    chk("t6_rst_hits", res_hits, 0);
    chk("t6_rst_cycles", res_cycles, 0);
    chk("t6_rst_ovf", res_ovf, 0);
    chk("t6_rst_lost", lost_cnt, 0);
    chk("t6_rst_busy", busy, 0);
    rst_n = 1'b1;
    drive(0, 1, 0);
    chk("t6_stop_after_rst", res_valid, 0);
    drive(0, 1, 0);
    chk("t6_idle_stop_valid", res_valid, 0);
    chk("t6_idle_stop_busy", busy, 0);
    // abort then short window
    drive(1, 0, 0);
    for (int i = 1; i <= 10; i++) drive(i == 10, 0, 0);
    chk("t6_abort_lost", lost_cnt, 1);
    chk("t6_abort_busy", busy, 1);
    for (int i = 1; i <= 5; i++) drive(0, i == 5, 0);
    chk("t6_abort_valid", res_valid, 1);
    chk("t6_abort_cycles", res_cycles, 5);
    drive(0, 0, 0);
    // minimum windows, one result per cycle
    drive(1, 0, 0);
    drive(1, 1, 1);
    chk("t7_n1_cycles", res_cycles, 1);
    chk("t7_n1_hits", res_hits, 1);
    drive(0, 1, 0);
    chk("t7_b2b_valid", res_valid, 1);
    chk("t7_b2b_hits", res_hits, 0);
    chk("t7_b2b_cycles", res_cycles, 1);
    chk("t7_lost", lost_cnt, 1);
    drive(0, 0, 0);
    chk("t7_final_valid", res_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hit_window_counter.md
# hit_window_counter

Counts detector hit edges inside each measurement window framed by the `start`/`stop` pulses of the slow start/stop generator in the hit-statistics path. It also measures each window's length in clock cycles. Each closed window produces one result (hit count, window length, overflow flag) through a single-entry valid/ready output register. Results that cannot be delivered are counted rather than stalling the window timing.

## Interface
- `CNT_WIDTH`, 24: width of the hit counter and `res_hits`.
- `WIN_WIDTH`, 20: width of the window-length counter and `res_cycles`; matches the generator's `windows` width.
- `clk40M`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle window-open pulse from the generator.
- `stop`  in  1  one-cycle window-close pulse from the generator.
- `hit_in`  in  1  hit level, synchronous to `clk40M`; each rising edge counts as one hit.
- `res_ready`  in  1  consumer accepts the result.
- `res_valid`  out  1  result register holds an unaccepted result.
- `res_hits`  out  CNT_WIDTH  hits in the closed window.
- `res_cycles`  out  WIN_WIDTH  window length in cycles.
- `res_ovf`  out  1  the hit counter or the window counter saturated during that window.
- `lost_cnt`  out  8  results dropped or windows aborted; saturates at 255.
- `busy`  out  1  the FSM is in COUNT.

## Operation
- **Hit edge detect**
  - `hit_q` is `hit_in` delayed by one cycle; it resets to 0.
  - A hit edge is `hit_in & ~hit_q`.
  - If `hit_in` is high on the first cycle after reset, that cycle counts as an edge.
- **FSM: IDLE, COUNT.**
  - IDLE, `start`=1: go to COUNT. Clear `hit_cnt`, `win_cnt` and `ovf_acc`.
  - IDLE, `stop`=1 with no `start`: ignored.
  - IDLE, `start` and `stop` in the same cycle: the window opens and `stop` is ignored.
  - COUNT, every cycle:
    - `win_cnt` increments, saturating at 2^WIN_WIDTH−1.
    - On a hit edge, `hit_cnt` increments, saturating at 2^CNT_WIDTH−1.
    - Any increment attempted while a counter is at its maximum sets `ovf_acc`.
  - COUNT, `stop`=1: close the window and hand its result to the result register (see below).
    - The final values include this cycle's increment.
    - If `start` is not also high, go to IDLE.
  - COUNT, `stop` and `start` together: close and deliver as above, then reopen immediately. The counters restart from 0 on the next cycle, and the FSM stays in COUNT.
  - COUNT, `start` without `stop`: abort.
    - The partial window is discarded and `lost_cnt` increments.
    - The counters clear and the FSM stays in COUNT.
- **Window accounting.** With `start` at cycle t and `stop` at cycle t+N:
  - `res_cycles` = N.
  - Hit edges in cycles t+1 through t+N are counted.
  - An edge in the `start` cycle itself is not counted.
- **Result register**
  - It loads on a window close when it is empty (`res_valid`=0) or being drained in that same cycle (`res_valid & res_ready`).
  - Otherwise the closed result is dropped and `lost_cnt` increments.
  - A transfer occurs in a cycle where `res_valid & res_ready`.
  - `res_valid` and the `res_*` data stay stable until transfer.
- **`lost_cnt`** is cumulative and never clears except on reset. An abort and a drop in the same cycle are impossible, because an abort requires no `stop`.

## Timing
- **Reset values:** every output is 0. The FSM is in IDLE, and all counters and `hit_q` are 0.
- **Reset mid-window:** the window is discarded and no result is produced. Counting resumes only after a new `start` following reset release.
- **Latency:** `stop` at cycle t gives `res_valid`=1 with the new data at cycle t+1 (registered output).
- **`busy`:** rises the cycle after an accepted `start`; falls the cycle after a `stop` that is not paired with `start`.
- **Back-to-back transfer:** a transfer at cycle t together with a close at cycle t keeps `res_valid` high at t+1, now holding the new data.
- **After transfer without a new close:** `res_valid`=0 at t+1.
- **Throughput:** one result per cycle is sustainable when `res_ready`=1. The minimum window is N=1.

## Test plan
1. **Basic window:** `start` at t0; `hit_in` pulses high for 2 cycles each at t0+5, t0+20 and t0+50; `stop` at t0+100; `res_ready`=1.
   - Expect `res_valid` high only at t0+101, with `res_hits`=3, `res_cycles`=100 and `res_ovf`=0.
2. **Edge boundaries:** hit edges at t0 (the `start` cycle) and at t0+10 (the `stop` cycle), with `stop` at t0+10.
   - Expect `res_hits`=1 and `res_cycles`=10.
3. **Backpressure:** `res_ready`=0; run two windows of 5 hits and then 7 hits.
   - Expect the first result (5) held stable and `lost_cnt`=1.
   - Then raise `res_ready`: transfer of the 5-hit result, then `res_valid`=0.
4. **Chained windows:** `start` at t0, then `stop`+`start` together at t0+40, then `stop` at t0+70; `res_ready`=1.
   - Expect two results with `res_cycles` of 40 and 30.
   - Expect `busy` to stay high from t0+1 to t0+70.
5. **Saturation:** with `CNT_WIDTH`=4, deliver 20 hit edges in one window.
   - Expect `res_hits`=15 and `res_ovf`=1.
   - The next window with 2 hits gives `res_ovf`=0.
6. **Reset and abort:**
   - `rst_n` low mid-window, then `stop`: no `res_valid`, all outputs 0.
   - `stop` in IDLE: no effect.
   - `start`, `start` again 10 cycles later, then `stop` 5 cycles after that: `lost_cnt`=1, `res_cycles`=5.
